nand_id_reader: RTL and testbench

NAND_ID_READER -- requirements
Module: nand_id_reader

---
 rtl/nand_pkg.sv | 34 +++
 rtl/nand_wait_timer.sv | 41 ++++
 rtl/nand_id_reader.sv | 209 ++++++++++++++++++++
 tb/tb_nand_id_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// Shared opcodes, FSM state type and command-selection helper for the NAND ID reader.
package nand_pkg;

   localparam logic [7:0] NAND_CMD_ENABLE    = 8'h09;
   localparam logic [7:0] NAND_CMD_DISABLE   = 8'h08;
   localparam logic [7:0] NAND_CMD_READ_ID   = 8'h03;
   localparam logic [7:0] NAND_CMD_READ_BYTE = 8'h0E;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRE    = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_GUARD  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_FINISH = 3'd5
   } nand_id_state_e;

   // Step 0 enables, step 1 reads the ID, the last step disables, everything between reads a byte.
   function automatic logic [7:0] nand_id_step_cmd(input logic [3:0] step,
                                                   input logic [3:0] last_step);
      logic [7:0] cmd;
      if (step == 4'd0) begin
         cmd = NAND_CMD_ENABLE;
      end else if (step == 4'd1) begin
         cmd = NAND_CMD_READ_ID;
      end else if (step == last_step) begin
         cmd = NAND_CMD_DISABLE;
      end else begin
         cmd = NAND_CMD_READ_BYTE;
      end
      return cmd;
   endfunction

endpackage

// File: rtl/nand_wait_timer.sv
// Load/expire watchdog counter used by nand_id_reader when NAND_ID_TIMEOUT_EN is defined.
module nand_wait_timer #(
   parameter int unsigned LIMIT = 4096
) (
   input  logic clk,
   input  logic nreset,
   input  logic load,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // expired means LIMIT cycles have been spent since the last load
   assign expired = (cnt_q >= CW'(LIMIT - 1));

   // Next count: restart on load, saturate once expired.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (run && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nand_id_reader.sv
// Drives a nand_master through enable / read-ID / ID_BYTES byte reads / disable and collects the ID.
// Optional watchdog on every busy wait is enabled by defining NAND_ID_TIMEOUT_EN.
module nand_id_reader
   import nand_pkg::*;
#(
   parameter int unsigned ID_BYTES       = 5,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  start,
   output logic                  done,
   output logic                  id_valid,
   output logic [8*ID_BYTES-1:0] id_bytes,
   output logic                  error,
   output logic [7:0]            nm_cmd,
   output logic                  nm_activate,
   output logic [7:0]            nm_data_in,
   input  logic                  nm_busy,
   input  logic [7:0]            nm_data_out
);

   localparam int unsigned IDW       = 8 * ID_BYTES;
   localparam logic [3:0]  LAST_STEP = 4'(ID_BYTES + 2);

   if ((ID_BYTES < 1) || (ID_BYTES > 8)) begin : g_bad_id_bytes
      $error("nand_id_reader: ID_BYTES must be 1..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("nand_id_reader: TIMEOUT_CYCLES must be at least 1");
   end

   nand_id_state_e state_q, state_d;
   logic [3:0]     step_q, step_d;
   logic           done_q, done_d;
   logic           id_valid_q, id_valid_d;
   logic [IDW-1:0] id_bytes_q, id_bytes_d;
   logic           nm_activate_q, nm_activate_d;
   logic [7:0]     nm_cmd_q, nm_cmd_d;
   logic [7:0]     nm_data_in_q, nm_data_in_d;
   logic           timeout_s;

`ifdef NAND_ID_TIMEOUT_EN
   logic timer_load_s;
   logic timer_run_s;
   logic timer_expired_s;
   logic error_q, error_d;

   // Restart the watchdog on every fresh entry into a busy wait.
   assign timer_run_s  = (state_q == ST_PRE) || (state_q == ST_WAIT);
   assign timer_load_s = ((state_d == ST_PRE) || (state_d == ST_WAIT)) && (state_d != state_q);
   assign timeout_s    = timer_run_s && nm_busy && timer_expired_s;

   nand_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .nreset  (nreset),
      .load    (timer_load_s),
      .run     (timer_run_s),
      .expired (timer_expired_s)
   );

   // Sticky abort flag, cleared when a new sequence is accepted.
   always_comb begin
      error_d = error_q;
      if ((state_q == ST_IDLE) && start) begin
         error_d = 1'b0;
      end else if (timeout_s) begin
         error_d = 1'b1;
      end else begin
         error_d = error_q;
      end
   end

   // Error register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   assign timeout_s = 1'b0;
   assign error     = 1'b0;
`endif

   // Sequencer next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      done_d        = 1'b0;
      id_valid_d    = id_valid_q;
      id_bytes_d    = id_bytes_q;
      nm_activate_d = 1'b0;
      nm_cmd_d      = nm_cmd_q;
      nm_data_in_d  = nm_data_in_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_PRE;
               step_d     = 4'd0;
               id_valid_d = 1'b0;
               id_bytes_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (timeout_s) begin
               state_d = ST_FINISH;
            end else if (!nm_busy) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_PRE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_GUARD;
         end
         // the master may not have raised busy yet, so this cycle never samples it
         ST_GUARD: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (timeout_s) begin
               state_d = ST_FINISH;
            end else if (!nm_busy) begin
               for (int k = 0; k < ID_BYTES; k++) begin
                  if (step_q == 4'(k + 2)) begin
                     id_bytes_d[8*k +: 8] = nm_data_out;
                  end else begin
                     id_bytes_d[8*k +: 8] = id_bytes_q[8*k +: 8];
                  end
               end
               if (step_q == LAST_STEP) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_PRE;
                  step_d  = step_q + 4'd1;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Command outputs are loaded on ISSUE entry so they are registered and hold afterwards.
      if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
         nm_activate_d = 1'b1;
         nm_cmd_d      = nand_id_step_cmd(step_q, LAST_STEP);
         if (step_q == 4'd1) begin
            nm_data_in_d = 8'h00;
         end else begin
            nm_data_in_d = nm_data_in_q;
         end
      end else begin
         nm_activate_d = 1'b0;
      end

      if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
         done_d     = 1'b1;
         id_valid_d = ~timeout_s;
      end else begin
         done_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q       <= ST_IDLE;
         step_q        <= 4'd0;
         done_q        <= 1'b0;
         id_valid_q    <= 1'b0;
         id_bytes_q    <= '0;
         nm_activate_q <= 1'b0;
         nm_cmd_q      <= 8'h00;
         nm_data_in_q  <= 8'h00;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         done_q        <= done_d;
         id_valid_q    <= id_valid_d;
         id_bytes_q    <= id_bytes_d;
         nm_activate_q <= nm_activate_d;
         nm_cmd_q      <= nm_cmd_d;
         nm_data_in_q  <= nm_data_in_d;
      end
   end

   assign done        = done_q;
   assign id_valid    = id_valid_q;
   assign id_bytes    = id_bytes_q;
   assign nm_activate = nm_activate_q;
   assign nm_cmd      = nm_cmd_q;
   assign nm_data_in  = nm_data_in_q;

endmodule

// File: tb/tb_nand_id_reader.sv
// Directed bench for nand_id_reader with a small nand_master behavioural model.
module tb_nand_id_reader;

   logic        clk;
   logic        nreset;
   logic        start;
   logic        done;
   logic        id_valid;
   logic [39:0] id_bytes;
   logic        error;
   logic [7:0]  nm_cmd;
   logic        nm_activate;
   logic [7:0]  nm_data_in;
   logic        nm_busy;
   logic [7:0]  nm_data_out;

   int checks = 0;
   int errors = 0;

   // nand_master model state
   logic [7:0] rom [0:7];
   int         rd_idx;
   int         busy_left;
   int         model_lat;
   logic       force_busy;

   // monitor state
   int         act_cnt = 0;
   int         done_cnt = 0;
   int         wide_cnt = 0;
   logic       prev_act = 1'b0;
   logic [7:0] cmd_log [0:255];

   nand_id_reader #(
      .ID_BYTES       (5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .nreset      (nreset),
      .start       (start),
      .done        (done),
      .id_valid    (id_valid),
      .id_bytes    (id_bytes),
      .error       (error),
      .nm_cmd      (nm_cmd),
      .nm_activate (nm_activate),
      .nm_data_in  (nm_data_in),
      .nm_busy     (nm_busy),
      .nm_data_out (nm_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // nand_master model: busy for model_lat cycles after each activate, serves bytes for 0x0E
   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         busy_left   <= 0;
         rd_idx      <= 0;
         nm_data_out <= 8'h00;
      end else if (nm_activate) begin
         busy_left <= model_lat;
         if (nm_cmd == 8'h03) rd_idx <= 0;
         if (nm_cmd == 8'h0E) begin
            nm_data_out <= rom[rd_idx % 8];
            rd_idx      <= rd_idx + 1;
         end
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
      end
   end
   assign nm_busy = force_busy || (busy_left != 0);

   // monitor sampled on the falling edge
   always @(negedge clk) begin
      if (nm_activate) begin
         cmd_log[act_cnt % 256] = nm_cmd;
         act_cnt = act_cnt + 1;
         if (prev_act) wide_cnt = wide_cnt + 1;
      end
      prev_act = nm_activate;
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic pulse_start;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles, output bit ok);
      int base;
      base   = done_cnt;
      cycles = 0;
      while ((done_cnt == base) && (cycles < budget)) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      ok = (done_cnt != base);
   endtask

   task automatic wait_acts(input int target, input int budget, output bit ok);
      int n;
      n = 0;
      while ((act_cnt < target) && (n < budget)) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = (act_cnt >= target);
   endtask

   task automatic load_rom_a;
      rom[0] = 8'h2C; rom[1] = 8'hE5; rom[2] = 8'hFF; rom[3] = 8'h03; rom[4] = 8'h86;
      rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'h00;
   endtask

   task automatic test_reset;
      nreset = 1'b0; start = 1'b0; force_busy = 1'b0; model_lat = 0;
      load_rom_a();
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (id_valid !== 1'b0)    begin errors++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
      checks++; if (id_bytes !== 40'h0)   begin errors++; $display("FAIL reset_id_bytes got %h want 0", id_bytes); end
      checks++; if (error !== 1'b0)       begin errors++; $display("FAIL reset_error got %b want 0", error); end
      checks++; if (nm_activate !== 1'b0) begin errors++; $display("FAIL reset_activate got %b want 0", nm_activate); end
      checks++; if (nm_cmd !== 8'h00)     begin errors++; $display("FAIL reset_cmd got %h want 00", nm_cmd); end
      checks++; if (nm_data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in got %h want 00", nm_data_in); end
      nreset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [7:0] exp_cmds [8];
      int  base_act, base_done, cyc;
      bit  ok;
      exp_cmds = '{8'h09, 8'h03, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 8'h08};
      model_lat = 0;
      load_rom_a();
      base_act  = act_cnt;
      base_done = done_cnt;
      pulse_start();
      wait_done(200, cyc, ok);
      checks++; if (!ok)                           begin errors++; $display("FAIL basic_done_seen got none want pulse"); end
      checks++; if (cyc !== 33)                    begin errors++; $display("FAIL basic_latency got %0d want 33", cyc); end
      checks++; if (id_bytes !== 40'h86_03_FF_E5_2C) begin errors++; $display("FAIL basic_id_bytes got %h want 8603ffe52c", id_bytes); end
      checks++; if (id_valid !== 1'b1)             begin errors++; $display("FAIL basic_id_valid got %b want 1", id_valid); end
      checks++; if (error !== 1'b0)                begin errors++; $display("FAIL basic_error got %b want 0", error); end
      repeat (5) @(negedge clk);
      #1;
      checks++; if (done_cnt - base_done !== 1)    begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - base_done); end
      checks++; if (act_cnt - base_act !== 8)      begin errors++; $display("FAIL basic_act_count got %0d want 8", act_cnt - base_act); end
      checks++; if (wide_cnt !== 0)                begin errors++; $display("FAIL basic_act_width got %0d wide want 0", wide_cnt); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (cmd_log[(base_act + i) % 256] !== exp_cmds[i]) begin
            errors++; $display("FAIL basic_cmd[%0d] got %h want %h", i, cmd_log[(base_act + i) % 256], exp_cmds[i]);
         end
      end
      checks++; if (nm_cmd !== 8'h08)              begin errors++; $display("FAIL basic_cmd_hold got %h want 08", nm_cmd); end
      checks++; if (id_valid !== 1'b1)             begin errors++; $display("FAIL basic_valid_hold got %b want 1", id_valid); end
   endtask

   task automatic test_busy_at_start;
      int  base_act, cyc;
      bit  ok;
      model_lat = 3;
      rom[0] = 8'h98; rom[1] = 8'hDA; rom[2] = 8'h10; rom[3] = 8'h95; rom[4] = 8'h44;
      force_busy = 1'b1;
      base_act   = act_cnt;
      pulse_start();
      repeat (10) @(negedge clk);
      #1;
      checks++; if (act_cnt - base_act !== 0) begin errors++; $display("FAIL busy_no_activate got %0d want 0", act_cnt - base_act); end
      force_busy = 1'b0;
      wait_done(400, cyc, ok);
      checks++; if (!ok)                       begin errors++; $display("FAIL busy_done_seen got none want pulse"); end
      checks++; if (id_bytes !== 40'h44_95_10_DA_98) begin errors++; $display("FAIL busy_id_bytes got %h want 449510da98", id_bytes); end
      checks++; if (act_cnt - base_act !== 8)  begin errors++; $display("FAIL busy_act_count got %0d want 8", act_cnt - base_act); end
   endtask

   task automatic test_back_to_back;
      int  base_act, base_done, cyc;
      bit  ok;
      model_lat = 2;
      load_rom_a();
      base_act  = act_cnt;
      base_done = done_cnt;
      pulse_start();
      repeat (7) @(negedge clk);
      pulse_start();
      wait_done(400, cyc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_done_seen got none want pulse"); end
      // start raised during the FINISH cycle must be dropped
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      checks++; if (done_cnt - base_done !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - base_done); end
      checks++; if (act_cnt - base_act !== 8)   begin errors++; $display("FAIL b2b_act_count got %0d want 8", act_cnt - base_act); end
      checks++; if (id_bytes !== 40'h86_03_FF_E5_2C) begin errors++; $display("FAIL b2b_id_bytes got %h want 8603ffe52c", id_bytes); end
   endtask

   task automatic test_reset_mid;
      int  base_act, cyc;
      bit  ok;
      model_lat = 3;
      load_rom_a();
      base_act = act_cnt;
      pulse_start();
      wait_acts(base_act + 5, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_third_read got %0d acts want 5", act_cnt - base_act); end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (id_bytes !== 40'h00_00_00_E5_2C) begin errors++; $display("FAIL rmid_partial got %h want 000000e52c", id_bytes); end
      #1;
      nreset = 1'b0;
      #1;
      checks++; if (id_bytes !== 40'h0)   begin errors++; $display("FAIL rmid_id_bytes got %h want 0", id_bytes); end
      checks++; if (nm_cmd !== 8'h00)     begin errors++; $display("FAIL rmid_cmd got %h want 00", nm_cmd); end
      checks++; if (id_valid !== 1'b0)    begin errors++; $display("FAIL rmid_valid got %b want 0", id_valid); end
      checks++; if (nm_activate !== 1'b0) begin errors++; $display("FAIL rmid_activate got %b want 0", nm_activate); end
      @(negedge clk);
      nreset = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      checks++; if (act_cnt - base_act !== 5) begin errors++; $display("FAIL rmid_no_disable got %0d acts want 5", act_cnt - base_act); end
      base_act = act_cnt;
      pulse_start();
      wait_done(400, cyc, ok);
      checks++; if (!ok)                        begin errors++; $display("FAIL rmid_restart_done got none want pulse"); end
      checks++; if (id_bytes !== 40'h86_03_FF_E5_2C) begin errors++; $display("FAIL rmid_restart_bytes got %h want 8603ffe52c", id_bytes); end
      checks++; if (id_valid !== 1'b1)          begin errors++; $display("FAIL rmid_restart_valid got %b want 1", id_valid); end
      checks++; if (cmd_log[base_act % 256] !== 8'h09) begin errors++; $display("FAIL rmid_restart_first got %h want 09", cmd_log[base_act % 256]); end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (act_cnt - base_act !== 8)   begin errors++; $display("FAIL rmid_restart_acts got %0d want 8", act_cnt - base_act); end
   endtask

`ifdef NAND_ID_TIMEOUT_EN
   task automatic test_timeout;
      int  base_act, base_done, cyc;
      bit  ok;
      model_lat = 3;
      load_rom_a();
      base_act  = act_cnt;
      base_done = done_cnt;
      pulse_start();
      wait_acts(base_act + 2, 200, ok);
      force_busy = 1'b1;
      checks++; if (!ok) begin errors++; $display("FAIL tmo_read_id got %0d acts want 2", act_cnt - base_act); end
      wait_done(200, cyc, ok);
      checks++; if (!ok)              begin errors++; $display("FAIL tmo_done_seen got none want pulse"); end
      checks++; if (error !== 1'b1)   begin errors++; $display("FAIL tmo_error got %b want 1", error); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL tmo_valid got %b want 0", id_valid); end
      repeat (10) @(negedge clk);
      #1;
      checks++; if (act_cnt - base_act !== 2)   begin errors++; $display("FAIL tmo_no_disable got %0d acts want 2", act_cnt - base_act); end
      checks++; if (done_cnt - base_done !== 1) begin errors++; $display("FAIL tmo_done_count got %0d want 1", done_cnt - base_done); end
      force_busy = 1'b0;
      repeat (5) @(negedge clk);
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "simulation watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_busy_at_start();
      test_back_to_back();
      test_reset_mid();
`ifdef NAND_ID_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
